scr1_imem_match_trace: RTL and testbench

//  Synthesizable on-chip counterpart of the fetch-stream instruction matcher.

---
 rtl/scr1_imem_match_trace.sv | 161 ++++++++++++++++
 tb/tb_scr1_imem_match_trace.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_imem_match_trace.sv
// scr1_imem_match_trace
// Snoops the IMEM response channel. Every OKAY response whose opcode and
// funct3 fields equal the programmed pattern captures the current pipe PC
// into a first-word-fall-through FIFO, which drains to a trace sink through
// a valid/ready handshake. Matches and drops are counted with saturation.
//
// Ports
//   clk, rst_n               core clock, synchronous active-low reset
//   imem_resp/rdata/curr_pc  snooped response, instruction word, pipe PC
//   cfg_en                   capture enable (level)
//   cfg_clr                  pulse: flush FIFO, clear counters, back to IDLE
//   cfg_opcode/cfg_funct3    match pattern for rdata[6:0] / rdata[14:12]
//   trc_vld/trc_rdy/trc_pc   FIFO head handshake and head PC
//   match_cnt/drop_cnt       saturating hit / dropped-hit counters
//   fifo_lvl                 FIFO occupancy
//   frozen                   capture stopped after an overflow
module scr1_imem_match_trace #(
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 16,
    parameter int STOP_ON_OVF = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               imem_resp,
    input  logic [31:0]              imem_rdata,
    input  logic [31:0]              curr_pc,
    input  logic                     cfg_en,
    input  logic                     cfg_clr,
    input  logic [6:0]               cfg_opcode,
    input  logic [2:0]               cfg_funct3,
    output logic                     trc_vld,
    input  logic                     trc_rdy,
    output logic [31:0]              trc_pc,
    output logic [CNT_W-1:0]         match_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [$clog2(DEPTH):0]   fifo_lvl,
    output logic                     frozen
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LVL_W-1:0]   wptr_q, wptr_d;
    logic [LVL_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [31:0]        mem_q [DEPTH];

    logic [LVL_W-1:0]   lvl;
    logic               full;
    logic               hit;
    logic               pop;
    logic               push;
    logic               drop;
    logic               mem_we;

    // Only opcode and funct3 take part in the compare.
    logic               unused_rdata;
    assign unused_rdata = ^{imem_rdata[31:15], imem_rdata[11:7]};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign lvl     = wptr_q - rptr_q;
    assign full    = (lvl == LVL_W'(DEPTH));
    assign trc_vld = (lvl != '0);
    assign pop     = trc_vld & trc_rdy;

    assign hit  = (state_q == ST_RUN) && (imem_resp == 2'b01) &&
                  (imem_rdata[6:0] == cfg_opcode) &&
                  (imem_rdata[14:12] == cfg_funct3);
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign push = hit & (~full | pop);
    assign drop = hit & full & ~pop;

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        match_cnt_d = match_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        mem_we      = 1'b0;
        if (cfg_clr) begin
            state_d     = ST_IDLE;
            wptr_d      = '0;
            rptr_d      = '0;
            match_cnt_d = '0;
            drop_cnt_d  = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + LVL_W'(1);
                mem_we = 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + LVL_W'(1);
            end
            if (hit) begin
                match_cnt_d = sat_inc(match_cnt_q);
            end
            if (drop) begin
                drop_cnt_d = sat_inc(drop_cnt_q);
            end
            case (state_q)
                ST_IDLE: begin
                    if (cfg_en) state_d = ST_RUN;
                end
                ST_RUN: begin
                    // An overflow freeze wins over a simultaneous disable.
                    if (drop && (STOP_ON_OVF != 0)) state_d = ST_FROZEN;
                    else if (!cfg_en)               state_d = ST_IDLE;
                end
                ST_FROZEN: begin
                    state_d = ST_FROZEN;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            match_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            match_cnt_q <= match_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Storage is data only; emptiness is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wptr_q[PTR_W-1:0]] <= curr_pc;
        end
    end

    // Head is forced to zero while empty so reset shows a clean trc_pc.
    assign trc_pc    = trc_vld ? mem_q[rptr_q[PTR_W-1:0]] : 32'h0;
    assign match_cnt = match_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign fifo_lvl  = lvl;
    assign frozen    = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_scr1_imem_match_trace.sv
module tb_scr1_imem_match_trace;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic [1:0]  imem_resp;
    logic [31:0] imem_rdata;
    logic [31:0] curr_pc;
    logic        cfg_en;
    logic        cfg_clr;
    logic [6:0]  cfg_opcode;
    logic [2:0]  cfg_funct3;
    logic        trc_rdy;

    logic        vld0, vld1, fz0, fz1;
    logic [31:0] pc0, pc1;
    logic [3:0]  mc0, dc0;
    logic [15:0] mc1, dc1;
    logic [3:0]  lvl0, lvl1;

    // Instance 0: keeps capturing through overflow, narrow counters.
    scr1_imem_match_trace #(.DEPTH(DEPTH), .CNT_W(4), .STOP_ON_OVF(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .curr_pc(curr_pc), .cfg_en(cfg_en), .cfg_clr(cfg_clr),
        .cfg_opcode(cfg_opcode), .cfg_funct3(cfg_funct3),
        .trc_vld(vld0), .trc_rdy(trc_rdy), .trc_pc(pc0),
        .match_cnt(mc0), .drop_cnt(dc0), .fifo_lvl(lvl0), .frozen(fz0));

    // Instance 1: freezes on the first drop.
    scr1_imem_match_trace #(.DEPTH(DEPTH), .CNT_W(16), .STOP_ON_OVF(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .curr_pc(curr_pc), .cfg_en(cfg_en), .cfg_clr(cfg_clr),
        .cfg_opcode(cfg_opcode), .cfg_funct3(cfg_funct3),
        .trc_vld(vld1), .trc_rdy(trc_rdy), .trc_pc(pc1),
        .match_cnt(mc1), .drop_cnt(dc1), .fifo_lvl(lvl1), .frozen(fz1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] a_pc [2];
    logic [31:0] a_mc [2];
    logic [31:0] a_dc [2];
    logic [31:0] a_lvl [2];
    logic        a_vld [2];
    logic        a_fz [2];
    assign a_pc[0] = pc0;          assign a_pc[1] = pc1;
    assign a_mc[0] = 32'(mc0);     assign a_mc[1] = 32'(mc1);
    assign a_dc[0] = 32'(dc0);     assign a_dc[1] = 32'(dc1);
    assign a_lvl[0] = 32'(lvl0);   assign a_lvl[1] = 32'(lvl1);
    assign a_vld[0] = vld0;        assign a_vld[1] = vld1;
    assign a_fz[0] = fz0;          assign a_fz[1] = fz1;

    // Reference model: mode 0 idle, 1 running, 2 frozen.
    int          cw    [2] = '{4, 16};
    int          stopf [2] = '{0, 1};
    int          m_mode [2], m_lvl [2], m_mc [2], m_dc [2];
    int          c_mode [2], c_lvl [2], c_mc [2], c_dc [2];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    bit          chk_en = 0;
    bit          was_rst = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic model_step(input int k);
        int  cmax;
        int  nm;
        bit  pop, hit;
        cmax = (1 << cw[k]) - 1;
        if (!rst_n || cfg_clr) begin
            m_mode[k] = 0; m_lvl[k] = 0; m_mc[k] = 0; m_dc[k] = 0;
            if (k == 0) q0.delete(); else q1.delete();
            return;
        end
        pop = (m_lvl[k] > 0) && trc_rdy;
        hit = (m_mode[k] == 1) && (imem_resp == 2'b01) &&
              (imem_rdata[6:0] == cfg_opcode) && (imem_rdata[14:12] == cfg_funct3);
        nm = m_mode[k];
        if (m_mode[k] == 0 && cfg_en)  nm = 1;
        if (m_mode[k] == 1 && !cfg_en) nm = 0;
        if (hit) begin
            if (m_mc[k] < cmax) m_mc[k]++;
            if (m_lvl[k] < DEPTH || pop) begin
                if (k == 0) q0.push_back(curr_pc); else q1.push_back(curr_pc);
                m_lvl[k]++;
            end else begin
                if (m_dc[k] < cmax) m_dc[k]++;
                if (stopf[k] != 0) nm = 2;
            end
        end
        if (pop) m_lvl[k]--;
        m_mode[k] = nm;
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        was_rst = !rst_n;
        for (int k = 0; k < 2; k++) begin
            c_mode[k] = m_mode[k]; c_lvl[k] = m_lvl[k];
            c_mc[k] = m_mc[k];     c_dc[k] = m_dc[k];
        end
        chk_en = 1;
    endtask

    task automatic drive(input logic [1:0] resp, input logic [31:0] rdata,
                         input logic [31:0] pc, input logic rdy);
        imem_resp = resp; imem_rdata = rdata; curr_pc = pc; trc_rdy = rdy;
    endtask

    function automatic logic [31:0] hit_word();
        logic [31:0] r;
        r = $urandom();
        return {r[31:15], cfg_funct3, r[11:7], cfg_opcode};
    endfunction

    task automatic chk(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    // Monitor: compares state every cycle, pops the scoreboard on handshake.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [31:0] head;
                int          qs;
                qs = (k == 0) ? q0.size() : q1.size();
                chk("trc_vld", k, 32'(a_vld[k]), 32'(c_lvl[k] > 0));
                chk("fifo_lvl", k, a_lvl[k], 32'(c_lvl[k]));
                chk("match_cnt", k, a_mc[k], 32'(c_mc[k]));
                chk("drop_cnt", k, a_dc[k], 32'(c_dc[k]));
                chk("frozen", k, 32'(a_fz[k]), 32'(c_mode[k] == 2));
                if (was_rst) chk("trc_pc_rst", k, a_pc[k], 32'h0);
                if (rst_n && !cfg_clr && c_lvl[k] > 0) begin
                    if (qs == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL scoreboard_empty[%0d] @%0t: got %h expected entry", k, $time, a_pc[k]);
                    end else begin
                        head = (k == 0) ? q0[0] : q1[0];
                        chk("trc_pc", k, a_pc[k], head);
                        if (a_vld[k] && trc_rdy) begin
                            if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; cfg_en = 1'b0; cfg_clr = 1'b0;
        cfg_opcode = 7'h33; cfg_funct3 = 3'h2;
        drive(2'b00, 32'h0, 32'h0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        // Disabled: a matching word must not be captured.
        drive(2'b01, 32'h0020A233, 32'h100, 1'b0);
        tick();
        cfg_en = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 1'b0);
        tick();
        drive(2'b01, 32'h0020A233, 32'h200, 1'b0);
        tick();
        drive(2'b10, 32'h0020A233, 32'h204, 1'b0);
        tick();
        cfg_funct3 = 3'h7;
        drive(2'b01, 32'h0020A233, 32'h208, 1'b0);
        tick();
        cfg_funct3 = 3'h2;
        drive(2'b00, 32'h0, 32'h0, 1'b1);
        tick();
        // Nine hits into a stalled, empty FIFO: eight stored, one dropped.
        for (int i = 0; i < 9; i++) begin
            drive(2'b01, hit_word(), 32'h1000 + 32'(i * 4), 1'b0);
            tick();
        end
        // Hit against a full FIFO while the sink pops.
        drive(2'b01, hit_word(), 32'h2000, 1'b1);
        tick();
        drive(2'b00, 32'h0, 32'h0, 1'b1);
        repeat (3) tick();
        // Reset in the middle of a drain.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 1'b1);
        tick();
        for (int i = 0; i < 12; i++) begin
            drive(2'b01, hit_word(), 32'h3000 + 32'(i * 4), 1'b0);
            tick();
        end
        cfg_clr = 1'b1;
        drive(2'b01, hit_word(), 32'h4000, 1'b1);
        tick();
        cfg_clr = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 1'b1);
        repeat (2) tick();
        // Randomized traffic with drifting sink back-pressure.
        for (int i = 0; i < 4000; i++) begin
            int rdy_pct;
            int rr;
            rdy_pct = ((i / 200) % 2 == 0) ? 25 : 75;
            rst_n   = ($urandom_range(0, 499) != 0);
            cfg_clr = ($urandom_range(0, 79) == 0);
            cfg_en  = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 149) == 0) begin
                cfg_opcode = ($urandom_range(0, 1) == 0) ? 7'h33 : 7'h13;
                cfg_funct3 = 3'($urandom_range(0, 7));
            end
            rr = $urandom_range(0, 9);
            imem_resp  = (rr < 7) ? 2'b01 : ((rr < 9) ? 2'b10 : 2'b00);
            imem_rdata = ($urandom_range(0, 9) < 6) ? hit_word() : $urandom();
            curr_pc    = $urandom();
            trc_rdy    = ($urandom_range(0, 99) < rdy_pct);
            tick();
        end
        rst_n = 1'b1; cfg_clr = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 1'b1);
        repeat (2) tick();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
